enc_sched: RTL

- Controller that sequences one image through the JPEG entropy encoder.
- Reads zig-zag-ordered quantised coefficients, one byte per address, from the coefficient buffer and streams them to the encoder as 64-byte MCUs.
- The encoder and its 32-bit output path have no backpressure, so each MCU is gated on downstream FIFO credit.
- Counts the packed output words, waits for the encoder pipeline to drain, then signals completion.

---
 rtl/enc_sched.sv | 119 +++++++++++
 1 files changed

// File: rtl/enc_sched.sv
// Sequences one image through the JPEG entropy encoder. Coefficients are streamed as
// 64-byte MCUs, and each MCU starts only when the downstream FIFO has enough credit.
module enc_sched #(
    parameter int NUM_MCU    = 256,
    parameter int CREDIT_MIN = 96,
    parameter int DRAIN_CYC  = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    input  logic [7:0]  fifo_free_i,
    output logic        mem_ren_o,
    output logic [13:0] mem_addr_o,
    input  logic [7:0]  mem_rdata_i,
    output logic [7:0]  enc_din_o,
    output logic        enc_din_valid_o,
    input  logic        enc_dout_valid_i,
    output logic [15:0] word_count_o,
    output logic [7:0]  mcu_idx_o
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [7:0]    LAST_MCU   = 8'(NUM_MCU - 1);
    localparam logic [7:0]    CREDIT_LVL = 8'(CREDIT_MIN);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {IDLE, CREDIT, READ, DRAIN, FIN} state_t;

    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic          ren_q;
    logic          valid_q;
    logic [7:0]    mcu_q;
    logic [5:0]    pix_q;
    logic [DW-1:0] drain_q;
    logic [15:0]   wc_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ren_q   <= 1'b0;
            valid_q <= 1'b0;
            mcu_q   <= '0;
            pix_q   <= '0;
            drain_q <= '0;
            wc_q    <= '0;
        end else begin
            valid_q <= ren_q;
            if (busy_q && enc_dout_valid_i && wc_q != 16'hFFFF) begin
                wc_q <= wc_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= CREDIT;
                        busy_q  <= 1'b1;
                        mcu_q   <= '0;
                        pix_q   <= '0;
                        drain_q <= '0;
                        wc_q    <= '0;
                    end
                end
                CREDIT: begin
                    if (fifo_free_i >= CREDIT_LVL) begin
                        state_q <= READ;
                        ren_q   <= 1'b1;
                    end
                end
                READ: begin
                    // The last MCU keeps its final address so mem_addr ends at the top of the image.
                    if (pix_q == 6'd63) begin
                        ren_q <= 1'b0;
                        if (mcu_q == LAST_MCU) begin
                            state_q <= DRAIN;
                        end else begin
                            mcu_q   <= mcu_q + 8'd1;
                            pix_q   <= '0;
                            state_q <= CREDIT;
                        end
                    end else begin
                        pix_q <= pix_q + 6'd1;
                    end
                end
                DRAIN: begin
                    // The drain window opens only once the last coefficient has left the valid register.
                    if (!valid_q) begin
                        if (drain_q == DRAIN_LAST) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            drain_q <= drain_q + 1'b1;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign mem_ren_o       = ren_q;
    assign mem_addr_o      = {mcu_q, pix_q};
    assign enc_din_o       = mem_rdata_i;
    assign enc_din_valid_o = valid_q;
    assign word_count_o    = wc_q;
    assign mcu_idx_o       = mcu_q;

endmodule
